// File: rtl/hood_pkg.sv
// Shared encodings for the smoker hood mode controller and its downstream consumers.
package hood_pkg;

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_STANDBY   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_L1        = 3'd1;
  localparam logic [MODE_W-1:0] MODE_L2        = 3'd2;
  localparam logic [MODE_W-1:0] MODE_HURRICANE = 3'd3;
  localparam logic [MODE_W-1:0] MODE_EXIT      = 3'd4;

  typedef enum logic [MODE_W-1:0] {
    ST_STANDBY   = MODE_STANDBY,
    ST_L1        = MODE_L1,
    ST_L2        = MODE_L2,
    ST_HURRICANE = MODE_HURRICANE,
    ST_EXIT      = MODE_EXIT
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, level debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The stable level flips only after the synchronised input disagrees for DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      press_q  <= stable_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hood_mode_ctrl.sv
// Hood button front end: debounced presses drive the mode FSM, 1 Hz prescaler and countdown.
// Define HOOD_HURRICANE_REARM_EN to let a completed exit-purge re-enable hurricane.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 500,
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned HURRICANE_S     = 60,
  parameter int unsigned EXIT_S          = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              menu_btn,
  input  logic              mode1_btn,
  input  logic              mode2_btn,
  input  logic              mode3_btn,
  output logic [MODE_W-1:0] mode_state,
  output logic [CNT_W-1:0]  countdown_s,
  output logic              hurricane_used,
  output logic              menu_armed,
  output logic              mode_changed
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [3:0] press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_menu (
    .clk(clk), .rst_n(rst), .btn_i(menu_btn), .press_o(press[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m1 (
    .clk(clk), .rst_n(rst), .btn_i(mode1_btn), .press_o(press[1]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m2 (
    .clk(clk), .rst_n(rst), .btn_i(mode2_btn), .press_o(press[2]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m3 (
    .clk(clk), .rst_n(rst), .btn_i(mode3_btn), .press_o(press[3]));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             used_q, used_d;
  logic             armed_q, armed_d;
  logic             changed_q;
  logic             tick, load;
  logic             ev_menu, ev_m1, ev_m2, ev_m3;

  // Only the highest-priority press in a cycle is acted on.
  assign ev_menu = press[0];
  assign ev_m3   = press[3] & ~press[0];
  assign ev_m2   = press[2] & ~press[0] & ~press[3];
  assign ev_m1   = press[1] & ~press[0] & ~press[3] & ~press[2];

  assign tick = (presc_q == PW'(CLK_HZ - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    armed_d = armed_q;
    load    = 1'b0;
    presc_d = tick ? '0 : presc_q + PW'(1);

    case (state_q)
      ST_STANDBY: begin
        if (ev_menu) begin
          armed_d = ~armed_q;
        end else if (armed_q) begin
          if (ev_m1) begin
            state_d = ST_L1;
            armed_d = 1'b0;
          end else if (ev_m2) begin
            state_d = ST_L2;
            armed_d = 1'b0;
          end else if (ev_m3 && !used_q) begin
            state_d = ST_HURRICANE;
            used_d  = 1'b1;
            cnt_d   = CNT_W'(HURRICANE_S);
            load    = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      ST_L1, ST_L2: begin
        if (ev_menu) begin
          state_d = ST_EXIT;
          cnt_d   = CNT_W'(EXIT_S);
          load    = 1'b1;
        end else if (ev_m1) begin
          state_d = ST_L1;
        end else if (ev_m2) begin
          state_d = ST_L2;
        end
      end
      ST_HURRICANE: begin
        if (ev_menu) begin
          state_d = ST_EXIT;
          cnt_d   = CNT_W'(EXIT_S);
          load    = 1'b1;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_L2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_EXIT: begin
        if (ev_m1) begin
          state_d = ST_L1;
          cnt_d   = '0;
        end else if (ev_m2) begin
          state_d = ST_L2;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_STANDBY;
            cnt_d   = '0;
`ifdef HOOD_HURRICANE_REARM_EN
            used_d  = 1'b0;
`else
            used_d  = used_q;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_STANDBY;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
    endcase

    // A countdown load restarts the second boundary and overrides a coincident tick.
    if (load) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_STANDBY;
      cnt_q     <= '0;
      presc_q   <= '0;
      used_q    <= 1'b0;
      armed_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      used_q    <= used_d;
      armed_q   <= armed_d;
      changed_q <= (state_d != state_q);
    end
  end

  assign mode_state     = state_q;
  assign countdown_s    = cnt_q;
  assign hurricane_used = used_q;
  assign menu_armed     = armed_q;
  assign mode_changed   = changed_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with small timing parameters and hand-computed expectations.
module tb_hood_mode_ctrl;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned DB     = 2;
  localparam int unsigned HS     = 3;
  localparam int unsigned ES     = 2;
  localparam int unsigned W      = DB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       menu_btn = 1'b0;
  logic       mode1_btn = 1'b0;
  logic       mode2_btn = 1'b0;
  logic       mode3_btn = 1'b0;
  logic [2:0] mode_state;
  logic [6:0] countdown_s;
  logic       hurricane_used;
  logic       menu_armed;
  logic       mode_changed;

  int tests = 0;
  int fails = 0;
  int chg_cnt = 0;
  int c0;

  hood_mode_ctrl #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .HURRICANE_S(HS), .EXIT_S(ES)
  ) dut (
    .clk(clk), .rst(rst),
    .menu_btn(menu_btn), .mode1_btn(mode1_btn), .mode2_btn(mode2_btn), .mode3_btn(mode3_btn),
    .mode_state(mode_state), .countdown_s(countdown_s), .hurricane_used(hurricane_used),
    .menu_armed(menu_armed), .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_changed) chg_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: menu_btn  = v;
      1: mode1_btn = v;
      2: mode2_btn = v;
      default: mode3_btn = v;
    endcase
  endtask

  task automatic tap(input int idx);
    set_btn(idx, 1'b1);
    cyc(W);
    set_btn(idx, 1'b0);
    cyc(W);
  endtask

  task automatic wait_change(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (mode_changed) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  initial begin
    // 1. reset state
    cyc(3);
    check("rst_mode", mode_state, 0);
    check("rst_cnt", countdown_s, 0);
    check("rst_flags", {hurricane_used, menu_armed, mode_changed}, 0);
    rst = 1'b1;
    cyc(2);

    // 2. mode press unarmed is ignored; menu arms; mode1 selects L1
    c0 = chg_cnt;
    tap(1);
    check("t2_unarmed_mode", mode_state, 0);
    check("t2_unarmed_chg", chg_cnt - c0, 0);
    tap(0);
    check("t2_armed", menu_armed, 1);
    set_btn(1, 1'b1);
    wait_change("t2_l1");
    check("t2_mode", mode_state, 1);
    check("t2_disarm", menu_armed, 0);
    set_btn(1, 1'b0);
    cyc(W);
    check("t2_one_pulse", chg_cnt - c0, 1);

    // back to standby via exit-purge, then arm
    set_btn(0, 1'b1);
    wait_change("t3_pre_exit");
    wait_change("t3_pre_standby");
    check("t3_pre_mode", mode_state, 0);
    set_btn(0, 1'b0);
    cyc(W);
    tap(0);
    check("t3_armed", menu_armed, 1);

    // 3. hurricane entry and timeout into L2
    set_btn(3, 1'b1);
    wait_change("t3_hur");
    check("t3_mode", mode_state, 3);
    check("t3_cnt", countdown_s, 3);
    check("t3_used", hurricane_used, 1);
    check("t3_disarm", menu_armed, 0);
    cyc(3);
    check("t3_cnt_e3", countdown_s, 3);
    cyc(1);
    check("t3_cnt_e4", countdown_s, 2);
    cyc(7);
    check("t3_mode_e11", mode_state, 3);
    check("t3_cnt_e11", countdown_s, 1);
    cyc(1);
    check("t3_mode_e12", mode_state, 2);
    check("t3_cnt_e12", countdown_s, 0);
    check("t3_chg_e12", mode_changed, 1);
    set_btn(3, 1'b0);
    cyc(W);

    // 4. L2 -> exit-purge -> standby after 8 clk
    set_btn(0, 1'b1);
    wait_change("t4_exit");
    check("t4_mode", mode_state, 4);
    check("t4_cnt", countdown_s, 2);
    cyc(7);
    check("t4_mode_e7", mode_state, 4);
    check("t4_cnt_e7", countdown_s, 1);
    cyc(1);
    check("t4_mode_e8", mode_state, 0);
    check("t4_cnt_e8", countdown_s, 0);
    set_btn(0, 1'b0);
    cyc(W);
    tap(0);
    check("t4_armed", menu_armed, 1);
`ifdef HOOD_HURRICANE_REARM_EN
    check("t4_rearm_used", hurricane_used, 0);
    set_btn(3, 1'b1);
    wait_change("t4_rehur");
    check("t4_rehur_mode", mode_state, 3);
    check("t4_rehur_used", hurricane_used, 1);
    set_btn(3, 1'b0);
    set_btn(0, 1'b1);
    wait_change("t4_rehur_exit");
    wait_change("t4_rehur_standby");
    check("t4_rehur_back", mode_state, 0);
    set_btn(0, 1'b0);
    cyc(W);
    tap(0);
    check("t4_rehur_armed", menu_armed, 1);
`else
    tap(3);
    check("t4_used_mode", mode_state, 0);
    check("t4_used_armed", menu_armed, 1);
    check("t4_used_flag", hurricane_used, 1);
`endif
    set_btn(1, 1'b1);
    wait_change("t5_pre_l1");
    check("t5_pre_mode", mode_state, 1);
    set_btn(1, 1'b0);
    cyc(W);

    // 5. simultaneous menu+mode2 from L1: menu wins; mode1 cancels exit
    menu_btn  = 1'b1;
    mode2_btn = 1'b1;
    wait_change("t5_exit");
    check("t5_mode", mode_state, 4);
    check("t5_cnt", countdown_s, 2);
    set_btn(1, 1'b1);
    wait_change("t5_cancel");
    check("t5_cancel_mode", mode_state, 1);
    check("t5_cancel_cnt", countdown_s, 0);
    menu_btn  = 1'b0;
    mode1_btn = 1'b0;
    mode2_btn = 1'b0;
    cyc(W);
    check("t5_stay", mode_state, 1);

    // 6. one-cycle glitch is rejected
    c0 = chg_cnt;
    set_btn(2, 1'b1);
    cyc(1);
    set_btn(2, 1'b0);
    cyc(W + 4);
    check("t6_glitch_mode", mode_state, 1);
    check("t6_glitch_chg", chg_cnt - c0, 0);

    // 6. asynchronous reset during hurricane
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(2);
    tap(0);
    set_btn(3, 1'b1);
    wait_change("t6_hur");
    check("t6_hur_mode", mode_state, 3);
    cyc(2);
    check("t6_hur_cnt", countdown_s, 3);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_mode", mode_state, 0);
    check("t6_arst_cnt", countdown_s, 0);
    check("t6_arst_flags", {hurricane_used, menu_armed, mode_changed}, 0);
    set_btn(3, 1'b0);
    cyc(2);
    rst = 1'b1;
    cyc(W);
    check("t6_post_used", hurricane_used, 0);
    check("t6_post_mode", mode_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
